// File: rtl/edge_detector_pkg.sv
// Shared mode encodings and arm-length helper for the multi-channel edge detector.
// The arm length depends on whether GLITCH_FILTER_EN is defined at build time.
package edge_detector_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Cycles after reset release during which detection stays suppressed.
  function automatic int arm_len(input int sync_stages, input int filter_len, input bit filt_en);
    return sync_stages + 1 + (filt_en ? filter_len : 0);
  endfunction

endpackage

// File: rtl/edge_detector_channel.sv
// One detector channel: synchroniser, optional glitch filter (GLITCH_FILTER_EN),
// edge detect, sticky flag and saturating event counter.
module edge_detector_channel
  import edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
`ifdef GLITCH_FILTER_EN
  ,
  parameter int FILTER_LEN  = 4
`endif
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_i,
  input  logic [1:0]       mode_i,
  input  logic             clear_i,
  input  logic             count_clr_i,
  input  logic             armed_i,
  output logic             pulse_o,
  output logic             sticky_o,
  output logic             sticky_nxt_o,
  output logic [CNT_W-1:0] count_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level;
  logic                   prev_q;
  logic                   pulse_q, pulse_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise, fall, rise_en, fall_en, evt;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], data_i};

`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN);

  logic          filt_q, filt_d;
  logic [FW-1:0] stab_q, stab_d;

  // Any cycle where the synchronised value agrees with the filter restarts the count.
  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (stab_q == FW'(FILTER_LEN - 1)) filt_d = sync_q[SYNC_STAGES-1];
      else                               stab_d = stab_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else begin
      filt_q <= filt_d;
      stab_q <= stab_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  always_comb begin
    rise     = level & ~prev_q;
    fall     = ~level & prev_q;
    rise_en  = (mode_i == MODE_RISE) || (mode_i == MODE_BOTH);
    fall_en  = (mode_i == MODE_FALL) || (mode_i == MODE_BOTH);
    evt      = armed_i && (mode_i != MODE_OFF) && ((rise_en && rise) || (fall_en && fall));
    pulse_d  = evt;
    sticky_d = evt | (sticky_q & ~clear_i);
    if (count_clr_i)        cnt_d = evt ? CNT_W'(1) : '0;
    else if (evt && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= level;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse_o      = pulse_q;
  assign sticky_o     = sticky_q;
  assign sticky_nxt_o = sticky_d;
  assign count_o      = cnt_q;

endmodule

// File: rtl/edge_detector_multi.sv
// Multi-channel edge detector top: arm counter, channel array, output packing and irq.
// Define GLITCH_FILTER_EN to insert a FILTER_LEN-cycle glitch filter in every channel.
module edge_detector_multi
  import edge_detector_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int FILTER_LEN  = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       data,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       clear,
  input  logic                      count_clr,
  output logic [CHANNELS-1:0]       edge_pulse,
  output logic [CHANNELS-1:0]       edge_sticky,
  output logic [CHANNELS*CNT_W-1:0] event_count,
  output logic                      irq
);

`ifdef GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  localparam int ARM_LEN = arm_len(SYNC_STAGES, FILTER_LEN, FILT_EN);
  localparam int ARM_W   = $clog2(ARM_LEN + 1);

  logic [ARM_W-1:0]    arm_q, arm_d;
  logic                armed;
  logic                irq_q, irq_d;
  logic [CHANNELS-1:0] sticky_nxt;

  // Saturates at ARM_LEN so detection stays enabled until the next reset.
  always_comb begin
    armed = (arm_q == ARM_W'(ARM_LEN));
    arm_d = armed ? arm_q : arm_q + 1'b1;
    irq_d = |sticky_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arm_q <= '0;
      irq_q <= 1'b0;
    end else begin
      arm_q <= arm_d;
      irq_q <= irq_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_detector_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
`ifdef GLITCH_FILTER_EN
      ,
      .FILTER_LEN  (FILTER_LEN)
`endif
    ) u_ch (
      .clk_i        (clock),
      .rst_ni       (reset_n),
      .data_i       (data[i]),
      .mode_i       (mode[2*i +: 2]),
      .clear_i      (clear[i]),
      .count_clr_i  (count_clr),
      .armed_i      (armed),
      .pulse_o      (edge_pulse[i]),
      .sticky_o     (edge_sticky[i]),
      .sticky_nxt_o (sticky_nxt[i]),
      .count_o      (event_count[CNT_W*i +: CNT_W])
    );
  end

  assign irq = irq_q;

endmodule

// File: doc/edge_detector_multi.md
Name: edge_detector_multi

Overview:
- Multi-channel, parametrised successor to the single-bit edge detector.
- Each channel synchronises an asynchronous input and detects rising, falling or both edges, selected per channel at run time.
- Each channel reports a one-cycle pulse, a sticky flag with per-channel clear, and a saturating event count.
- Sits between raw external/async signals and the control/interrupt logic. A single irq summarises all sticky flags.

Parameters:
- CHANNELS, 4, number of independent input channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- CNT_W, 8, width of each channel's event counter (>=1).
- FILTER_LEN, 4, stable-cycle count required by the glitch filter (>=2). Used only when GLITCH_FILTER_EN is defined.

Ports:
- clock  input  1  rising-edge system clock.
- reset_n  input  1  asynchronous, active-low reset.
- data  input  CHANNELS  raw async inputs; bit i belongs to channel i.
- mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- clear  input  CHANNELS  write-1 clear of edge_sticky[i].
- count_clr  input  1  synchronous clear of all event counters.
- edge_pulse  output  CHANNELS  one-cycle pulse per qualifying edge.
- edge_sticky  output  CHANNELS  latched event flag.
- event_count  output  CHANNELS*CNT_W  per-channel saturating counts; channel i at [CNT_W*i +: CNT_W].
- irq  output  1  OR of edge_sticky.

Behaviour:
- Reset (async assert, sync release): all outputs 0; synchroniser, previous-level and filter state 0; arm counter 0.
- Arming: after reset release, detection is suppressed for SYNC_STAGES+1 cycles.
  - Pipeline fills without reporting events, so an input already high at release produces no event.
  - Arm counter saturates; thereafter armed=1 permanently until the next reset.
- Synchroniser: sync[0] captures data[i] at clock edge E; level reaches the last stage at E+SYNC_STAGES-1.
- Detection:
  - prev <= level every cycle.
  - rise = level & ~prev; fall = ~level & prev.
  - Qualifying event = armed & ((mode[0] & rise) | (mode[1] & fall)).
- Latency: edge_pulse[i] is registered and goes high at edge E+SYNC_STAGES, for exactly one cycle per level transition.
  - Level toggling every cycle with mode 11 gives a pulse every cycle.
- Mode changes:
  - Take effect on the next detection cycle; no retroactive events.
  - Mode 00 produces no pulses; sticky flag and counter hold their values.
- Sticky flag:
  - Set on a qualifying event; cleared when clear[i]=1.
  - Set and clear in the same cycle: set wins.
- Counter:
  - Increments on each qualifying event; saturates at 2^CNT_W-1 with no wrap.
  - count_clr zeros all counters; count_clr and an event in the same cycle load 1.
- irq: registered OR of next-state sticky bits, so it tracks edge_sticky with no extra lag.
- Reset mid-operation: immediate clear of all state and outputs; re-arming is required after release.
- Inputs narrower than the synchroniser sampling window may be missed; this is accepted.

Optional Feature:
- Macro: GLITCH_FILTER_EN.
- Defined:
  - A per-channel filter sits between the synchroniser output and level.
  - filtered level changes only after the synchronised value has differed from it for FILTER_LEN consecutive cycles; a shorter excursion resets the stability counter.
  - Latency grows by FILTER_LEN cycles.
  - Arming period becomes SYNC_STAGES+FILTER_LEN+1 cycles.
- Undefined: level = synchroniser output; no filter logic is generated; FILTER_LEN is ignored.

Decomposition:
- Package edge_detector_pkg:
  - Mode constants MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11.
  - Function computing the arm length from the parameters.
- Sub-module edge_detector_channel, generated CHANNELS times. It contains the synchroniser, optional filter, detect logic, sticky flag and counter; it takes an armed input.
- Top level holds the arm counter, output packing and irq.

Test Plan (CHANNELS=4, SYNC_STAGES=2, CNT_W=8, clock period 10):
- data=4'b1111 held through reset release, mode=all 01 -> no edge_pulse during or after arming; all counts 0; irq=0.
- ch0 mode 01; data[0] 0->1 sampled at edge E -> edge_pulse[0] high only in the cycle after edge E+2; sticky[0]=1; count0=1; irq=1.
- ch1 mode 11; data[1] toggled 5 times -> 5 pulses; count1=5. Switch to mode 10 and toggle 4 times -> 2 more pulses; count1=7.
- ch2 mode 10; clear[2] pulsed in the same cycle a falling-edge event sets the flag -> sticky[2] stays 1. A later clear alone -> sticky[2]=0; irq drops when all flags are 0.
- ch3 mode 11; 300 toggles -> count3 saturates at 255. count_clr asserted coincident with an event -> count3=1.
- GLITCH_FILTER_EN, FILTER_LEN=4: a 3-cycle high glitch on ch0 -> no pulse. A 6-cycle high -> one rise pulse 4 cycles later than the unfiltered build. reset_n asserted mid-sequence -> all outputs 0 at once.
